// File: rtl/silly_fn_bist.sv
`default_nettype none
// ============================================================================
// silly_fn_bist : BIST sequencer sweeping {a,b,c}=0..7 through SillyFunction.
// Optional per-vector fail log: define SILLY_FN_BIST_FAILLOG_EN.   Rev 1.0
// ============================================================================
module silly_fn_bist #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECT        = 8'h35
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec
`ifdef SILLY_FN_BIST_FAILLOG_EN
  ,
  output logic [7:0] fail_mask
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] vec_q;
  logic [3:0] cnt_q;
  logic [2:0] abc_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] fail_count_q;
  logic       fail_valid_q;
  logic [2:0] first_fail_vec_q;
`ifdef SILLY_FN_BIST_FAILLOG_EN
  logic [7:0] fail_mask_q;
`endif

  logic w_mismatch;
  assign w_mismatch = (dut_y != EXPECT[vec_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      vec_q            <= 3'd0;
      cnt_q            <= 4'd0;
      abc_q            <= 3'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      fail_count_q     <= 4'd0;
      fail_valid_q     <= 1'b0;
      first_fail_vec_q <= 3'd0;
`ifdef SILLY_FN_BIST_FAILLOG_EN
      fail_mask_q      <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q          <= ST_SETTLE;
            vec_q            <= 3'd0;
            cnt_q            <= 4'd0;
            abc_q            <= 3'd0;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            fail_count_q     <= 4'd0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= 3'd0;
`ifdef SILLY_FN_BIST_FAILLOG_EN
            fail_mask_q      <= 8'd0;
`endif
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == C_CNT_LAST) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // dut_y is only trusted here; the vector has been held S cycles.
          if (w_mismatch) begin
            fail_count_q <= fail_count_q + 4'd1;
`ifdef SILLY_FN_BIST_FAILLOG_EN
            fail_mask_q[vec_q] <= 1'b1;
`endif
            if (!fail_valid_q) begin
              fail_valid_q     <= 1'b1;
              first_fail_vec_q <= vec_q;
            end
          end
          if (vec_q == 3'd7) begin
            state_q <= ST_DONE;
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
            vec_q   <= vec_q + 3'd1;
            abc_q   <= vec_q + 3'd1;
            cnt_q   <= 4'd0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c}      = abc_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (fail_count_q == 4'd0);
  assign fail_count     = fail_count_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_vec_q;
`ifdef SILLY_FN_BIST_FAILLOG_EN
  assign fail_mask      = fail_mask_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_silly_fn_bist.sv
`default_nettype none
// ============================================================================
// tb_silly_fn_bist : directed checks of silly_fn_bist with S=2 and S=1.
// Rev 1.0
// ============================================================================
module tb_silly_fn_bist;

  // Truth table of SillyFunction: 000->1 001->0 010->1 011->0 100->1 101->1 110->0 111->0
  localparam logic [7:0] c_TRUTH = 8'b0011_0101;

  localparam int c_MODE_GOOD   = 0;
  localparam int c_MODE_STUCK0 = 1;
  localparam int c_MODE_INV    = 2;
  localparam int c_MODE_FLIP6  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start2 = 1'b0;
  logic start1 = 1'b0;
  int   mode2 = c_MODE_GOOD;
  int   mode1 = c_MODE_FLIP6;

  logic       a2, b2, c2, busy2, done2, pass2, fv2;
  logic [3:0] fc2;
  logic [2:0] ffv2;
  logic       a1, b1, c1, busy1, done1, pass1, fv1;
  logic [3:0] fc1;
  logic [2:0] ffv1;
  logic       y2, y1;
`ifdef SILLY_FN_BIST_FAILLOG_EN
  logic [7:0] mask2, mask1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic model(input int m, input logic [2:0] v);
    case (m)
      c_MODE_GOOD:   return c_TRUTH[v];
      c_MODE_STUCK0: return 1'b0;
      c_MODE_INV:    return ~c_TRUTH[v];
      default:       return (v == 3'd6) ? 1'b1 : c_TRUTH[v];
    endcase
  endfunction

  assign y2 = model(mode2, {a2, b2, c2});
  assign y1 = model(mode1, {a1, b1, c1});

  silly_fn_bist #(.SETTLE_CYCLES(2), .EXPECT(8'h35)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .dut_y(y2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fc2), .fail_valid(fv2), .first_fail_vec(ffv2)
`ifdef SILLY_FN_BIST_FAILLOG_EN
    , .fail_mask(mask2)
`endif
  );

  silly_fn_bist #(.SETTLE_CYCLES(1), .EXPECT(8'h35)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .dut_y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .fail_valid(fv1), .first_fail_vec(ffv1)
`ifdef SILLY_FN_BIST_FAILLOG_EN
    , .fail_mask(mask1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until done rises (bounded).
  task automatic wait_done2(output int n);
    n = 0;
    while (!done2 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_start2();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
  endtask

  int n;

  initial begin
    tick();
    tick();
    reset = 1'b0;

    check("rst_abc",   {29'd0, a2, b2, c2}, 32'd0);
    check("rst_busy",  busy2, 1'b0);
    check("rst_done",  done2, 1'b0);
    check("rst_pass",  pass2, 1'b0);
    check("rst_fc",    fc2, 4'd0);
    check("rst_fv",    fv2, 1'b0);
    check("rst_ffv",   ffv2, 3'd0);
`ifdef SILLY_FN_BIST_FAILLOG_EN
    check("rst_mask",  mask2, 8'h00);
`endif

    // Good DUT, S=2
    mode2 = c_MODE_GOOD;
    pulse_start2();
    check("good_busy0", busy2, 1'b1);
    check("good_abc0",  {29'd0, a2, b2, c2}, 32'd0);
    wait_done2(n);
    check("good_lat",  n, 24);
    check("good_busy", busy2, 1'b0);
    check("good_pass", pass2, 1'b1);
    check("good_fc",   fc2, 4'd0);
    check("good_fv",   fv2, 1'b0);
`ifdef SILLY_FN_BIST_FAILLOG_EN
    check("good_mask", mask2, 8'h00);
`endif
    tick();
    check("good_hold", done2, 1'b1);

    // Stuck-at-0 output
    mode2 = c_MODE_STUCK0;
    pulse_start2();
    wait_done2(n);
    check("s0_lat",  n, 24);
    check("s0_fc",   fc2, 4'd4);
    check("s0_fv",   fv2, 1'b1);
    check("s0_ffv",  ffv2, 3'd0);
    check("s0_pass", pass2, 1'b0);
`ifdef SILLY_FN_BIST_FAILLOG_EN
    check("s0_mask", mask2, 8'h35);
`endif

    // Start accepted from DONE clears results; inverted DUT
    mode2 = c_MODE_INV;
    pulse_start2();
    check("rd_done", done2, 1'b0);
    check("rd_busy", busy2, 1'b1);
    check("rd_fc",   fc2, 4'd0);
    check("rd_fv",   fv2, 1'b0);
    wait_done2(n);
    check("inv_lat", n, 24);
    check("inv_fc",  fc2, 4'd8);
    check("inv_ffv", ffv2, 3'd0);
    check("inv_pass", pass2, 1'b0);
`ifdef SILLY_FN_BIST_FAILLOG_EN
    check("inv_mask", mask2, 8'hFF);
`endif

    // Reset during vector 3
    mode2 = c_MODE_STUCK0;
    pulse_start2();
    repeat (10) tick();
    check("mid_abc", {29'd0, a2, b2, c2}, 32'd3);
    check("mid_fc",  fc2, 4'd2);
    reset = 1'b1;
    start2 = 1'b1;
    tick();
    reset = 1'b0;
    start2 = 1'b0;
    check("mr_abc",  {29'd0, a2, b2, c2}, 32'd0);
    check("mr_busy", busy2, 1'b0);
    check("mr_done", done2, 1'b0);
    check("mr_fc",   fc2, 4'd0);
    check("mr_fv",   fv2, 1'b0);
    tick();
    check("mr_idle", busy2, 1'b0);
    mode2 = c_MODE_GOOD;
    pulse_start2();
    wait_done2(n);
    check("mr_lat",  n, 24);
    check("mr_pass", pass2, 1'b1);

    // Start re-pulsed mid-run is ignored
    mode2 = c_MODE_STUCK0;
    pulse_start2();
    repeat (5) tick();
    pulse_start2();
    wait_done2(n);
    check("rp_lat", n + 6, 24);
    check("rp_fc",  fc2, 4'd4);

    // S=1 instance, vector 110 flipped
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin
      tick();
      n++;
    end
    check("f6_lat",  n, 16);
    check("f6_fc",   fc1, 4'd1);
    check("f6_fv",   fv1, 1'b1);
    check("f6_ffv",  ffv1, 3'd6);
    check("f6_pass", pass1, 1'b0);
`ifdef SILLY_FN_BIST_FAILLOG_EN
    check("f6_mask", mask1, 8'h40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/silly_fn_bist.md
# silly_fn_bist

Built-in self-test sequencer for the 3-input `SillyFunction` combinational block. On `start` it drives all 8 input vectors `{a,b,c}` = 000..111 in ascending order and waits a programmable settle time per vector. It then compares the block's `y` against a parameterised truth table and accumulates a pass/fail result. It sits beside `SillyFunction` in the lab top level, replacing manual stimulus, and owns the block's inputs whenever it is busy.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before `y` is sampled; legal range 1..15.
- `EXPECT`, default 8'h35: expected `y`, indexed by vector value `{a,b,c}`. Bit n is the expected output for vector n: 000→1, 001→0, 010→1, 011→0, 100→1, 101→1, 110→0, 111→0.

Ports (one clock; reset is synchronous, active-high):
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high; returns the block to IDLE.
- `start` input 1: single-cycle or level request; sampled only in IDLE or DONE.
- `dut_y` input 1: `y` output of the `SillyFunction` under test.
- `a`, `b`, `c` output 1 each: registered drive to the DUT inputs.
- `busy` output 1: high in SETTLE and CHECK.
- `done` output 1: high in DONE, held until the next accepted `start` or `reset`.
- `pass` output 1: `done && fail_count == 0`.
- `fail_count` output 4: number of mismatching vectors, range 0..8.
- `fail_valid` output 1: at least one mismatch recorded this run.
- `first_fail_vec` output 3: vector index of the first mismatch; valid only when `fail_valid` = 1.
- `fail_mask` output 8: bit n set if vector n mismatched. Present only with the macro (see Configuration).

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Internal registers: `vec` (3 b) and `cnt` (4 b).
- IDLE:
  - `a/b/c` = 000.
  - `start` = 1 → SETTLE, with `vec` = 0, `cnt` = 0, `fail_count` = 0, `fail_valid` = 0, `first_fail_vec` = 0, `fail_mask` = 0.
- SETTLE:
  - `{a,b,c}` = `vec`; `cnt` increments each cycle.
  - When `cnt == SETTLE_CYCLES-1` → CHECK.
- CHECK (one cycle): sample `dut_y`.
  - On a mismatch (`dut_y != EXPECT[vec]`): `fail_count` +1, `fail_mask[vec]` set. If `fail_valid` = 0, also set `first_fail_vec` = `vec` and `fail_valid` = 1.
  - If `vec` = 7 → DONE. Otherwise `vec` +1, `cnt` = 0, → SETTLE.
- DONE:
  - `a/b/c` = 000; results held.
  - `start` = 1 → SETTLE, with the same clearing as from IDLE.
- `start` in SETTLE or CHECK is ignored; the run is not restarted.
- `fail_count` saturates naturally at 8 and never wraps.
- `dut_y` is X-safe only in CHECK; it is ignored in all other states.

## Timing
- Reset values: state IDLE; `a` = `b` = `c` = 0; `busy` = 0; `done` = 0; `pass` = 0; `fail_count` = 0; `fail_valid` = 0; `first_fail_vec` = 0; `fail_mask` = 0.
- Each vector occupies exactly `SETTLE_CYCLES + 1` cycles: S in SETTLE, 1 in CHECK.
- `start` sampled at edge k. Vector 0 is driven after edge k. The CHECK for vector n occurs in the cycle ending at edge k + (n+1)(S+1).
- `done` rises after edge k + 8(S+1). That is 24 cycles for the default S = 2.
- The `a/b/c` change and `busy` are registered: same-edge as the state change, no combinational path from `start`.
- `pass` is combinational from registered state only.
- `reset` mid-run: at the next edge all outputs return to their reset values. Partial results are discarded.
- `reset` and `start` in the same cycle: reset wins.

## Configuration
- Macro: `SILLY_FN_BIST_FAILLOG_EN`.
- Defined: `fail_mask[7:0]` port exists and records per-vector mismatches as described.
- Undefined: the `fail_mask` port is omitted and its register is not built. All other behaviour and timing are identical.

## Test plan
- Correct DUT model, S = 2, `start` pulse at cycle 0 → `busy` for 24 cycles, `done` = 1, `pass` = 1, `fail_count` = 0, `fail_valid` = 0, `fail_mask` = 8'h00.
- `dut_y` stuck at 0 → `fail_count` = 4, `first_fail_vec` = 0, `fail_mask` = 8'h35, `pass` = 0.
- `dut_y` = ~model → `fail_count` = 8, `first_fail_vec` = 0, `fail_mask` = 8'hFF.
- Model with vector 110 flipped (y = 1), S = 1 → `done` 16 cycles after `start`, `fail_count` = 1, `first_fail_vec` = 6, `fail_mask` = 8'h40.
- `reset` asserted during vector 3 → next cycle IDLE, `a/b/c` = 000, `busy` = 0, `fail_count` = 0. A subsequent `start` completes a full 8-vector run.
- `start` re-pulsed mid-run → ignored, `done` at the original cycle. `start` in DONE → results clear and a new run begins the next cycle.
